// File: rtl/enhanced_pkg.sv
`default_nettype none
// ============================================================================
// Module  : enhanced_pkg
// Brief   : Shared opcode, state and A-source encodings for the enhanced
//           accumulator controller.
// Revision: 1.0 - initial release
// ============================================================================
package enhanced_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_LOADIR = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_INREL  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

endpackage
`default_nettype wire

// File: rtl/enhanced_sync.sv
`default_nettype none
// ============================================================================
// Module  : enhanced_sync
// Brief   : Reset-clearable multi-flop synchroniser for an asynchronous level.
// Revision: 1.0 - initial release
// ============================================================================
module enhanced_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] r_stages;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stages <= '0;
    end else begin
      r_stages[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stages[i] <= r_stages[i-1];
      end
    end
  end

  assign sync_out = r_stages[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/enhanced_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : enhanced_ctrl
// Brief   : Fetch/decode/execute sequencer for the enhanced 8-bit accumulator
//           datapath, with operator IN handshake and retired-instruction count.
// Revision: 1.0 - initial release
// ============================================================================
module enhanced_ctrl
  import enhanced_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       ir,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic             enter,
  output logic             IRload,
  output logic             PCload,
  output logic             JMPmux,
  output logic             Meminst,
  output logic             MemWr,
  output logic             Aload,
  output logic             sub,
  output logic [1:0]       Asel,
  output logic             halted,
  output logic             wait_in,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] icount
);

  state_t           r_state;
  state_t           w_next;
  logic             w_enter_s;
  logic             w_retire;
  logic [CNT_W-1:0] r_icount;

  enhanced_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(enter),
    .sync_out(w_enter_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_FETCH;
      r_icount <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_icount <= r_icount + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    IRload   = 1'b0;
    PCload   = 1'b0;
    JMPmux   = 1'b0;
    Meminst  = 1'b0;
    MemWr    = 1'b0;
    Aload    = 1'b0;
    sub      = 1'b0;
    Asel     = ASEL_ALU;
    halted   = 1'b0;
    wait_in  = 1'b0;
    case (r_state)
      ST_FETCH:  w_next = ST_LOADIR;
      ST_LOADIR: begin
        IRload = 1'b1;
        PCload = 1'b1;
        w_next = ST_DECODE;
      end
      ST_DECODE: begin
        Meminst = 1'b1;
        if (ir == OP_HALT) begin
          w_next   = ST_HALT;
          w_retire = 1'b1;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
        case (ir)
          OP_LOAD: begin
            Aload = 1'b1;
            Asel  = ASEL_MEM;
          end
          OP_ADD:  Aload = 1'b1;
          OP_SUB: begin
            Aload = 1'b1;
            sub   = 1'b1;
          end
          OP_STORE: begin
            MemWr   = 1'b1;
            Meminst = 1'b1;
          end
          OP_JZ: begin
            PCload = Aeq0;
            JMPmux = Aeq0;
          end
          OP_JPOS: begin
            PCload = Apos;
            JMPmux = Apos;
          end
          OP_IN: begin
            // Load happens once on the synchronised press; INREL then waits for release
            wait_in = 1'b1;
            if (w_enter_s) begin
              Aload  = 1'b1;
              Asel   = ASEL_IN;
              w_next = ST_INREL;
            end else begin
              w_next   = ST_EXEC;
              w_retire = 1'b0;
            end
          end
          default: ;
        endcase
      end
      ST_INREL: if (!w_enter_s) w_next = ST_FETCH;
      ST_HALT:  halted = 1'b1;
      default:  w_next = ST_FETCH;
    endcase
  end

  assign state_o = r_state;
  assign icount  = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_enhanced_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_enhanced_ctrl
// Brief   : Self-checking bench for enhanced_ctrl (table vectors, corner
//           sequences, random instructions and a behavioural datapath program).
// Revision: 1.0 - initial release
// ============================================================================
module tb_enhanced_ctrl;
  import enhanced_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ir    = 3'b000;
  logic       Aeq0  = 1'b0;
  logic       Apos  = 1'b0;
  logic       enter = 1'b0;

  logic IRload, PCload, JMPmux, Meminst, MemWr, Aload, sub, halted, wait_in;
  logic [1:0]  Asel;
  logic [2:0]  state_o;
  logic [15:0] icount;

  logic d4_IRload, d4_PCload, d4_JMPmux, d4_Meminst, d4_MemWr, d4_Aload, d4_sub;
  logic d4_halted, d4_wait_in;
  logic [1:0] d4_Asel;
  logic [2:0] d4_state_o;
  logic [3:0] d4_icount;

  enhanced_ctrl #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .ir(ir), .Aeq0(Aeq0), .Apos(Apos), .enter(enter),
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
    .MemWr(MemWr), .Aload(Aload), .sub(sub), .Asel(Asel), .halted(halted),
    .wait_in(wait_in), .state_o(state_o), .icount(icount)
  );

  enhanced_ctrl #(.SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .ir(ir), .Aeq0(Aeq0), .Apos(Apos), .enter(enter),
    .IRload(d4_IRload), .PCload(d4_PCload), .JMPmux(d4_JMPmux), .Meminst(d4_Meminst),
    .MemWr(d4_MemWr), .Aload(d4_Aload), .sub(d4_sub), .Asel(d4_Asel), .halted(d4_halted),
    .wait_in(d4_wait_in), .state_o(d4_state_o), .icount(d4_icount)
  );

  always #5 clock = ~clock;

  int checks  = 0;
  int errors  = 0;
  int retired = 0;

  typedef struct {
    logic [2:0]  op;
    logic        aeq0;
    logic        apos;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe bundle order: IRload PCload JMPmux Meminst MemWr Aload sub Asel[1:0] halted wait_in
  function automatic logic [10:0] mk(input logic irl, input logic pcl, input logic jmp,
                                     input logic mi, input logic mw, input logic al,
                                     input logic sb, input logic [1:0] as,
                                     input logic h, input logic w);
    return {irl, pcl, jmp, mi, mw, al, sb, as, h, w};
  endfunction

  function automatic logic [10:0] strobes();
    return {IRload, PCload, JMPmux, Meminst, MemWr, Aload, sub, Asel, halted, wait_in};
  endfunction

  function automatic logic [10:0] strobes4();
    return {d4_IRload, d4_PCload, d4_JMPmux, d4_Meminst, d4_MemWr, d4_Aload, d4_sub,
            d4_Asel, d4_halted, d4_wait_in};
  endfunction

  // Reference EXEC strobes from the instruction semantics
  function automatic logic [10:0] exec_ref(input logic [2:0] op, input logic z, input logic p);
    logic writes_a, jump, st;
    writes_a = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
    jump     = ((op == OP_JZ) && z) || ((op == OP_JPOS) && p);
    st       = (op == OP_STORE);
    return mk(1'b0, jump, jump, st, st, writes_a, op == OP_SUB,
              (op == OP_LOAD) ? ASEL_MEM : ASEL_ALU, 1'b0, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    enter   = 1'b0;
    ir      = OP_LOAD;
    #3;
    reset   = 1'b0;
    retired = 0;
  endtask

  // Runs one non-IN instruction from FETCH; flags are noise except in EXEC
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic p, input logic [10:0] exp_exec);
    logic [10:0] phase_exp[4];
    phase_exp[0] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    phase_exp[1] = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    phase_exp[2] = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    phase_exp[3] = exp_exec;
    ir = op;
    for (int ph = 0; ph < 4; ph++) begin
      if (ph == 3) begin
        Aeq0 = z;
        Apos = p;
      end else begin
        Aeq0 = 1'($urandom);
        Apos = 1'($urandom);
      end
      #1;
      check({name, "_state"}, 32'(state_o), 32'(ph));
      check({name, "_strobes"}, 32'(strobes()), 32'(phase_exp[ph]));
      check({name, "_d4_strobes"}, 32'(strobes4()), 32'(phase_exp[ph]));
      tick();
    end
    retired++;
    check({name, "_icount"}, 32'(icount), 32'(retired % 65536));
    check({name, "_d4_icount"}, 32'(d4_icount), 32'(retired % 16));
  endtask

  logic [7:0] ram[32];
  logic [7:0] m_a, m_ir, m_mdr;
  logic [4:0] m_pc, m_addr;
  logic [10:0] s;
  logic       prev_wait, prev_inrel, store_seen;
  int         aload_cnt;

  initial begin
    tbl[0] = '{OP_LOAD,  1'b0, 1'b1, mk(0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 0)};
    tbl[1] = '{OP_STORE, 1'b1, 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0)};
    tbl[2] = '{OP_ADD,   1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0)};
    tbl[3] = '{OP_SUB,   1'b1, 1'b1, mk(0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0)};
    tbl[4] = '{OP_JZ,    1'b1, 1'b0, mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0)};
    tbl[5] = '{OP_JZ,    1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)};
    tbl[6] = '{OP_JPOS,  1'b0, 1'b1, mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0)};
    tbl[7] = '{OP_JPOS,  1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)};

    // Reset state
    enter = 1'b1;
    #12;
    check("rst_state", 32'(state_o), 0);
    check("rst_strobes", 32'(strobes()), 0);
    check("rst_icount", 32'(icount), 0);
    enter = 1'b0;
    reset = 1'b0;

    foreach (tbl[i]) run_instr($sformatf("vec%0d", i), tbl[i].op, tbl[i].aeq0, tbl[i].apos, tbl[i].exp);

    // IN handshake
    ir = OP_IN;
    tick(); tick(); tick();
    for (int k = 0; k < 10; k++) begin
      Aeq0 = 1'($urandom);
      #1;
      check("in_wait_state", 32'(state_o), 3);
      check("in_wait_strobes", 32'(strobes()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1)));
      tick();
    end
    enter = 1'b1;
    aload_cnt = 0;
    #1;
    if (Aload) aload_cnt++;
    tick();
    check("in_sync1_strobes", 32'(strobes()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1)));
    if (Aload) aload_cnt++;
    tick();
    check("in_load_strobes", 32'(strobes()), 32'(mk(0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 1)));
    if (Aload) aload_cnt++;
    tick();
    retired++;
    check("in_icount", 32'(icount), 32'(retired));
    for (int k = 0; k < 5; k++) begin
      check("inrel_state", 32'(state_o), 4);
      check("inrel_strobes", 32'(strobes()), 0);
      if (Aload) aload_cnt++;
      tick();
    end
    check("in_aload_once", 32'(aload_cnt), 1);
    enter = 1'b0;
    tick();
    check("inrel_rel1", 32'(state_o), 4);
    tick();
    check("inrel_rel2", 32'(state_o), 4);
    tick();
    check("in_back_fetch", 32'(state_o), 0);
    check("in_icount_after", 32'(icount), 32'(retired));

    // HALT: reached three cycles after FETCH, sticky, enter ignored
    ir = OP_HALT;
    tick(); tick();
    check("halt_decode", 32'(strobes()), 32'(mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0)));
    tick();
    retired++;
    check("halt_state", 32'(state_o), 5);
    check("halt_icount", 32'(icount), 32'(retired));
    enter = 1'b1;
    ir = OP_LOAD;
    for (int k = 0; k < 4; k++) tick();
    check("halt_sticky", 32'(strobes()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0)));
    check("halt_icount_hold", 32'(icount), 32'(retired));

    // Reset mid-IN wait
    do_reset();
    run_instr("pre_in", OP_LOAD, 1'b0, 1'b0, tbl[0].exp);
    ir = OP_IN;
    tick(); tick(); tick(); tick();
    check("midin_wait", 32'(wait_in), 1);
    reset = 1'b1;
    #1;
    check("midin_rst_state", 32'(state_o), 0);
    check("midin_rst_strobes", 32'(strobes()), 0);
    check("midin_rst_icount", 32'(icount), 0);
    do_reset();
    run_instr("post_in_rst", OP_ADD, 1'b0, 1'b0, tbl[2].exp);

    // Reset mid-EXEC STORE
    ir = OP_STORE;
    tick(); tick(); tick();
    check("midst_memwr", 32'(MemWr), 1);
    reset = 1'b1;
    #1;
    check("midst_rst_state", 32'(state_o), 0);
    check("midst_rst_memwr", 32'(MemWr), 0);
    check("midst_rst_icount", 32'(icount), 0);
    do_reset();
    run_instr("post_st_rst", OP_LOAD, 1'b0, 1'b0, tbl[0].exp);

    // Random instruction stream against the reference
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      logic z, p;
      op = 3'($urandom_range(0, 5));
      if (op >= OP_IN) op = op + 3'd1;
      z = 1'($urandom);
      p = 1'($urandom);
      run_instr("rnd", op, z, p, exec_ref(op, z, p));
    end

    // Counter wrap: 17 LOADs on a 4-bit counter lands on 1
    do_reset();
    for (int n = 0; n < 17; n++) run_instr("wrap", OP_LOAD, 1'b0, 1'b0, tbl[0].exp);
    check("wrap_icount4", 32'(d4_icount), 1);
    check("wrap_icount16", 32'(icount), 17);

    // Program on a behavioural datapath: IN; SUB [31]; JZ 4; JPOS 1; HALT
    do_reset();
    foreach (ram[i]) ram[i] = 8'h00;
    ram[0] = {OP_IN, 5'd0};
    ram[1] = {OP_SUB, 5'd31};
    ram[2] = {OP_JZ, 5'd4};
    ram[3] = {OP_JPOS, 5'd1};
    ram[4] = {OP_HALT, 5'd0};
    ram[31] = 8'd1;
    m_a = 8'h00; m_ir = 8'h00; m_mdr = 8'h00; m_pc = 5'd0;
    prev_wait = 1'b0; prev_inrel = 1'b0; store_seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [7:0] old_mdr, old_ir, old_a;
      ir   = m_ir[7:5];
      Aeq0 = (m_a == 8'd0);
      Apos = ~m_a[7];
      if (prev_wait) enter = 1'b1;
      if (prev_inrel) enter = 1'b0;
      #1;
      s = strobes();
      if (MemWr) store_seen = 1'b1;
      if (halted) break;
      prev_wait  = wait_in;
      prev_inrel = (state_o == 3'd4);
      old_mdr = m_mdr; old_ir = m_ir; old_a = m_a;
      m_addr = Meminst ? old_ir[4:0] : m_pc;
      if (MemWr) ram[m_addr] = old_a;
      else       m_mdr = ram[m_addr];
      if (IRload) m_ir = old_mdr;
      if (PCload) m_pc = JMPmux ? old_ir[4:0] : m_pc + 5'd1;
      if (Aload) begin
        case (Asel)
          2'b00:   m_a = sub ? old_a - old_mdr : old_a + old_mdr;
          2'b01:   m_a = 8'd3;
          default: m_a = old_mdr;
        endcase
      end
      tick();
    end
    check("prog_halted", 32'(halted), 1);
    check("prog_a", 32'(m_a), 0);
    check("prog_icount", 32'(icount), 10);
    check("prog_no_store", 32'(store_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
